// File: rtl/ps2_kb_rx.sv
// ps2_kb_rx: PS/2 keyboard receiver with E0/F0 decode, show-ahead entry FIFO and LED latch.
// Define PS2_RX_TYPEMATIC_FILTER_EN to drop typematic repeats of the last make code.
module ps2_kb_rx #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 1000,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    code_data,
    output logic                          code_ext,
    output logic                          code_break,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [7:0]                    led_g
);
    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0] CNT_ONE = 1;
    localparam logic [AW:0] CNT_FULL = FIFO_DEPTH;
    localparam logic [AW-1:0] PTR_ONE = 1;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic clk_prev, clk_s, data_s, fe;
    logic [3:0] bitcnt;
    logic [TW-1:0] timer;
    logic [9:0] sh;
    logic ext_pend, brk_pend;
    logic frame_ok, is_pre, drop, err_c, push_c, push_ok, pop, full;
    logic [9:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fe = clk_prev & ~clk_s;
    assign frame_ok = (^sh[8:0]) & sh[9];
    assign is_pre = sh[7:0] == 8'hE0 || sh[7:0] == 8'hF0;
    assign full = fifo_count == CNT_FULL;
    assign code_valid = fifo_count != '0;
    assign pop = code_valid & code_ready;
    assign push_ok = push_c & (~full | pop);
    assign {code_ext, code_break, code_data} = mem[rp];
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic lm_valid;
    assign drop = !brk_pend && lm_valid && last_make == {ext_pend, sh[7:0]};
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_make <= '0;
            lm_valid <= 1'b0;
        end else if (state == CHECK && frame_ok && !is_pre) begin
            if (!brk_pend) begin
                last_make <= {ext_pend, sh[7:0]};
                lm_valid <= 1'b1;
            end else if (last_make == {ext_pend, sh[7:0]}) begin
                lm_valid <= 1'b0;
            end
        end
    end
`else
    assign drop = 1'b0;
`endif
    always_comb begin
        state_n = state;
        err_c = 1'b0;
        push_c = 1'b0;
        case (state)
            IDLE: state_n = (fe && !data_s) ? SHIFT : IDLE;
            SHIFT: begin
                if (fe && bitcnt == 4'd9) begin
                    state_n = CHECK;
                end else if (!fe && timer == TW'(TIMEOUT_CYC - 1)) begin
                    state_n = IDLE;
                    err_c = 1'b1;
                end
            end
            CHECK: begin
                state_n = IDLE;
                err_c = !frame_ok;
                push_c = frame_ok && !is_pre && !drop;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= '0;
            data_sync <= '0;
            clk_prev <= 1'b0;
            state <= IDLE;
            bitcnt <= '0;
            timer <= '0;
            sh <= '0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            frame_err <= 1'b0;
            overflow <= 1'b0;
            led_g <= '0;
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_s;
            state <= state_n;
            frame_err <= err_c;
            overflow <= push_c & full & ~pop;
            timer <= (state == SHIFT && !fe && state_n == SHIFT) ? timer + TW'(1) : '0;
            bitcnt <= state != SHIFT ? 4'd0 : fe ? bitcnt + 4'd1 : bitcnt;
            if (state == SHIFT && fe)
                sh <= {data_s, sh[9:1]};
            // Prefix flags survive a timeout but not a corrupted frame.
            if (state == CHECK) begin
                ext_pend <= frame_ok && (sh[7:0] == 8'hE0 || (is_pre && ext_pend));
                brk_pend <= frame_ok && (sh[7:0] == 8'hF0 || (is_pre && brk_pend));
            end
            if (push_ok && !brk_pend)
                led_g <= sh[7:0];
            if (push_ok)
                wp <= wp + PTR_ONE;
            if (pop)
                rp <= rp + PTR_ONE;
            fifo_count <= (push_ok && !pop) ? fifo_count + CNT_ONE :
                          (!push_ok && pop) ? fifo_count - CNT_ONE : fifo_count;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (push_ok) begin
            mem[wp] <= {ext_pend, brk_pend, sh[7:0]};
        end
    end
endmodule
